// File: rtl/change_dispense_ctrl.sv
// Change payout controller: greedy coin selection over four denominations with
// per-denomination inventory, refill, ack timeout and short-change reporting.
module change_dispense_ctrl #(
  parameter int CW       = 8,
  parameter int INV_INIT = 8,
  parameter int ACK_TO   = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [CW-1:0] amount,
  output logic          disp_valid,
  output logic [1:0]    disp_sel,
  input  logic          disp_ack,
  input  logic          refill,
  input  logic [1:0]    refill_sel,
  input  logic [3:0]    refill_cnt,
  output logic          busy,
  output logic          done,
  output logic          short_err,
  output logic          fault,
  output logic [CW-1:0] remaining,
  output logic [3:0]    empty_mask
);

  localparam int WW = (ACK_TO < 2) ? 1 : $clog2(ACK_TO + 1);

  typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, FAULT} state_t;

  state_t          state, state_nxt;
  logic [7:0]      inv [4];
  logic [WW-1:0]   wait_cnt;
  logic            pick_ok;
  logic [1:0]      pick_sel;
  logic            ack_hit;
  logic            timeout;

  function automatic logic [CW-1:0] denom(input logic [1:0] sel);
    case (sel)
      2'd0:    denom = CW'(1);
      2'd1:    denom = CW'(2);
      2'd2:    denom = CW'(5);
      default: denom = CW'(10);
    endcase
  endfunction

  // Net inventory update, saturating at 255; decrement at 0 cannot occur.
  function automatic logic [7:0] inv_sat(input logic [7:0] cur, input logic dec,
                                         input logic [3:0] add);
    logic [8:0] sum;
    sum = {1'b0, cur} + {5'b0, add} - {8'b0, dec};
    inv_sat = (sum > 9'd255) ? 8'hff : sum[7:0];
  endfunction

  assign ack_hit = (state == DISPENSE) && disp_ack;
  assign timeout = (state == DISPENSE) && !disp_ack && (wait_cnt == WW'(ACK_TO - 1));

  // Ascending scan so the largest qualifying denomination wins.
  always_comb begin
    pick_ok  = 1'b0;
    pick_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (inv[i] != 8'd0 && denom(2'(i)) <= remaining) begin
        pick_ok  = 1'b1;
        pick_sel = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req) state_nxt = SELECT;
      SELECT: begin
        if (remaining == '0)  state_nxt = IDLE;
        else if (pick_ok)     state_nxt = DISPENSE;
        else                  state_nxt = IDLE;
      end
      DISPENSE: begin
        if (disp_ack)         state_nxt = SELECT;
        else if (timeout)     state_nxt = FAULT;
      end
      default:                state_nxt = FAULT;
    endcase
  end

  always_comb begin
    disp_valid = (state == DISPENSE);
    busy       = (state != IDLE);
    fault      = (state == FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      wait_cnt  <= '0;
      disp_sel  <= 2'd0;
      done      <= 1'b0;
      short_err <= 1'b0;
    end else begin
      done      <= (state == SELECT) && (remaining == '0);
      short_err <= (state == SELECT) && (remaining != '0) && !pick_ok;
      if (state == IDLE && req)
        remaining <= amount;
      else if (ack_hit)
        remaining <= remaining - denom(disp_sel);
      if (state == SELECT && pick_ok) begin
        disp_sel <= pick_sel;
        wait_cnt <= '0;
      end else if (state == DISPENSE && !disp_ack) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) inv[i] <= 8'(INV_INIT);
    end else begin
      for (int i = 0; i < 4; i++)
        inv[i] <= inv_sat(inv[i], ack_hit && (disp_sel == 2'(i)),
                          (refill && refill_sel == 2'(i)) ? refill_cnt : 4'd0);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) empty_mask[i] = (inv[i] == 8'd0);
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: greedy payout, short change,
// ack timeout, refill saturation and asynchronous reset mid-dispense.
module tb_change_dispense_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic [7:0] amount = '0;
  logic       disp_valid;
  logic [1:0] disp_sel;
  logic       disp_ack = 1'b0;
  logic       refill = 1'b0;
  logic [1:0] refill_sel = '0;
  logic [3:0] refill_cnt = '0;
  logic       busy, done, short_err, fault;
  logic [7:0] remaining;
  logic [3:0] empty_mask;

  int vectors = 0;
  int miscompares = 0;

  change_dispense_ctrl #(.CW(8), .INV_INIT(8), .ACK_TO(15)) dut (
    .clk(clk), .reset(reset), .req(req), .amount(amount),
    .disp_valid(disp_valid), .disp_sel(disp_sel), .disp_ack(disp_ack),
    .refill(refill), .refill_sel(refill_sel), .refill_cnt(refill_cnt),
    .busy(busy), .done(done), .short_err(short_err), .fault(fault),
    .remaining(remaining), .empty_mask(empty_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    chk("reset_outputs", {busy, done, short_err, fault, disp_valid, disp_sel, remaining, empty_mask}, 0);
    reset = 1'b0;
  endtask

  task automatic start(input logic [7:0] amt);
    req = 1'b1;
    amount = amt;
    tick();
    req = 1'b0;
  endtask

  // Enter DISPENSE from SELECT, wait one cycle, ack, then check the paid-down value.
  task automatic coin(input string tag, input logic [1:0] sel, input logic [7:0] rem);
    tick();
    chk({tag, "_valid"}, disp_valid, 1);
    chk({tag, "_sel"}, disp_sel, sel);
    tick();
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    chk({tag, "_rem"}, {disp_valid, remaining}, {1'b0, rem});
  endtask

  // Payout with immediate ack; only the final done is checked.
  task automatic pay_fast(input logic [7:0] amt);
    start(amt);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || short_err) break;
      if (disp_valid) begin
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
      end
    end
    chk("pay_fast_done", {done, short_err}, 2'b10);
  endtask

  initial begin
    // Greedy payout of 18 from full inventory
    do_reset();
    start(8'd18);
    chk("t1_busy", {busy, remaining, disp_valid}, {1'b1, 8'd18, 1'b0});
    coin("t1_c10", 2'b11, 8'd8);
    coin("t1_c5", 2'b10, 8'd3);
    coin("t1_c2", 2'b01, 8'd1);
    coin("t1_c1", 2'b00, 8'd0);
    tick();
    chk("t1_done", {done, busy, short_err, fault}, 4'b1000);
    tick();
    chk("t1_done_pulse", done, 0);
    for (int i = 0; i < 4; i++) chk("t1_inv", dut.inv[i], 8'd7);

    // No fives left: 7 is paid as 2+2+2+1
    do_reset();
    for (int n = 0; n < 8; n++) pay_fast(8'd5);
    chk("t2_empty5", empty_mask, 4'b0100);
    start(8'd7);
    coin("t2_a", 2'b01, 8'd5);
    coin("t2_b", 2'b01, 8'd3);
    coin("t2_c", 2'b01, 8'd1);
    coin("t2_d", 2'b00, 8'd0);
    tick();
    chk("t2_done", {done, busy}, 2'b10);
    chk("t2_inv2", dut.inv[1], 8'd5);
    chk("t2_inv1", dut.inv[0], 8'd7);

    // No ones or twos: 3 cannot be paid
    do_reset();
    for (int n = 0; n < 8; n++) pay_fast(8'd2);
    for (int n = 0; n < 8; n++) pay_fast(8'd1);
    chk("t3_empty", empty_mask, 4'b0011);
    start(8'd3);
    chk("t3_select", {disp_valid, busy}, 2'b01);
    tick();
    chk("t3_short", {short_err, done, busy, disp_valid, remaining}, {4'b1000, 8'd3});
    tick();
    chk("t3_short_pulse", short_err, 0);

    // Ack withheld: FAULT after 15 wait cycles, sticky until reset
    do_reset();
    start(8'd10);
    tick();
    chk("t4_valid", {disp_valid, disp_sel}, 3'b111);
    repeat (14) tick();
    chk("t4_pre_fault", {disp_valid, fault}, 2'b10);
    tick();
    chk("t4_fault", {fault, disp_valid, busy, done, short_err}, 5'b10100);
    disp_ack = 1'b1;
    req = 1'b1;
    amount = 8'd5;
    repeat (3) tick();
    disp_ack = 1'b0;
    req = 1'b0;
    chk("t4_fault_hold", {fault, disp_valid, busy}, 3'b101);

    // Refill saturation and refill+ack on the same saturated denomination
    do_reset();
    refill = 1'b1;
    refill_sel = 2'b11;
    refill_cnt = 4'd15;
    repeat (17) tick();
    refill = 1'b0;
    chk("t5_sat", dut.inv[3], 8'd255);
    start(8'd10);
    tick();
    chk("t5_sel", {disp_valid, disp_sel}, 3'b111);
    disp_ack = 1'b1;
    refill = 1'b1;
    refill_cnt = 4'd5;
    tick();
    disp_ack = 1'b0;
    refill = 1'b0;
    chk("t5_inv10", dut.inv[3], 8'd255);
    chk("t5_rem", remaining, 8'd0);
    tick();
    chk("t5_done", done, 1);

    // Asynchronous reset in the middle of DISPENSE
    do_reset();
    start(8'd10);
    tick();
    chk("t6_valid", disp_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async", {busy, done, short_err, fault, disp_valid, disp_sel, remaining}, 0);
    chk("t6_inv10", dut.inv[3], 8'd8);
    tick();
    reset = 1'b0;
    start(8'd5);
    coin("t6_c5", 2'b10, 8'd0);
    tick();
    chk("t6_done", {done, busy}, 2'b10);
    chk("t6_inv5", dut.inv[2], 8'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
